// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES packet input FIFO.
//   - word tag encodings carried in the top two bits of each host word
//   - accepted packet lengths (in words, header and EOP included)
//   - write-side FSM state type and encodings
package aes_pkg;

    localparam logic [1:0] TAG_BODY = 2'b00;
    localparam logic [1:0] TAG_SOP  = 2'b01;
    localparam logic [1:0] TAG_EOP  = 2'b10;
    localparam logic [1:0] TAG_BAD  = 2'b11;

    localparam logic [7:0] LEN_A = 8'd25;
    localparam logic [7:0] LEN_B = 8'd27;
    localparam logic [7:0] LEN_C = 8'd29;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RECV = 2'd1;
    localparam state_t ST_SKIP = 2'd2;

    function automatic logic len_ok(input logic [7:0] len);
        return (len == LEN_A) || (len == LEN_B) || (len == LEN_C);
    endfunction

endpackage

// File: rtl/aes_dpram.sv
// aes_dpram: simple dual-port RAM, 2^AW words of DW bits.
// Ports:
//   clk, rst_n     - clock, async active-low reset (read register only)
//   we/waddr/wdata - write port, written on rising edge
//   re/raddr       - read enable and address
//   rdata          - registered read data, holds when re is low
module aes_dpram #(
    parameter int AW = 6,
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes_pkt_in_fifo.sv
// aes_pkt_in_fifo: store-and-forward packet FIFO in front of the AES core.
// Packet words are written speculatively and only become readable once a
// length-consistent EOP commits them; malformed packets are rolled back.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   i_wr        - host write strobe, i_data_in = {tag[1:0], payload[31:0]}
//   o_full      - no free storage word
//   i_rd        - read strobe from the core; o_data_out valid next cycle
//   o_empty     - no committed word available
//   o_drop      - one-cycle pulse per discarded packet or stray word
//   o_pkt_cnt   - committed packet count (wraps)
//   o_drop_cnt  - drop pulse count (wraps)
module aes_pkt_in_fifo
    import aes_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_data_in,
    output logic          o_full,
    input  logic          i_rd,
    output logic [DW-1:0] o_data_out,
    output logic          o_empty,
    output logic          o_drop,
    output logic [7:0]    o_pkt_cnt,
    output logic [7:0]    o_drop_cnt
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_GAP = {1'b1, {AW{1'b0}}};

    logic [AW:0]   rd_ptr, wr_ptr, wr_cmt;
    logic [AW:0]   wr_ptr_d, wr_cmt_d;
    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d, len_q, len_d;
    logic          drop_d, pkt_inc, start_hdr;
    logic          we, rd_en, cmt_full;
    logic [AW-1:0] waddr;
    logic [1:0]    tag;
    logic [7:0]    hdr_len, cnt_inc;

    assign tag     = i_data_in[DW-1:DW-2];
    assign hdr_len = i_data_in[7:0];
    assign cnt_inc = cnt_q + 8'd1;

    assign o_empty  = (rd_ptr == wr_cmt);
    assign o_full   = ((wr_ptr - rd_ptr) == FULL_GAP);
    // Fullness as seen after a rollback to the committed pointer.
    assign cmt_full = ((wr_cmt - rd_ptr) == FULL_GAP);
    assign rd_en    = i_rd && !o_empty;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr;
        wr_cmt_d  = wr_cmt;
        cnt_d     = cnt_q;
        len_d     = len_q;
        drop_d    = 1'b0;
        pkt_inc   = 1'b0;
        start_hdr = 1'b0;
        we        = 1'b0;
        waddr     = wr_ptr[AW-1:0];

        if (i_wr) begin
            case (state_q)
                ST_RECV: begin
                    if (o_full) begin
                        // Overflow: the packet can never complete.
                        wr_ptr_d = wr_cmt;
                        drop_d   = 1'b1;
                        state_d  = ST_SKIP;
                    end else begin
                        case (tag)
                            TAG_BODY: begin
                                if (cnt_inc < len_q) begin
                                    we       = 1'b1;
                                    wr_ptr_d = wr_ptr + PTR_ONE;
                                    cnt_d    = cnt_inc;
                                end else begin
                                    wr_ptr_d = wr_cmt;
                                    drop_d   = 1'b1;
                                    state_d  = ST_SKIP;
                                end
                            end
                            TAG_EOP: begin
                                if (cnt_inc == len_q) begin
                                    we       = 1'b1;
                                    wr_ptr_d = wr_ptr + PTR_ONE;
                                    wr_cmt_d = wr_ptr + PTR_ONE;
                                    pkt_inc  = 1'b1;
                                end else begin
                                    wr_ptr_d = wr_cmt;
                                    drop_d   = 1'b1;
                                end
                                state_d = ST_IDLE;
                            end
                            TAG_SOP: begin
                                // Abandon current packet, restart on this header.
                                wr_ptr_d  = wr_cmt;
                                drop_d    = 1'b1;
                                start_hdr = 1'b1;
                            end
                            default: begin
                                wr_ptr_d = wr_cmt;
                                drop_d   = 1'b1;
                                state_d  = ST_SKIP;
                            end
                        endcase
                    end
                end
                ST_SKIP: begin
                    if (tag == TAG_SOP) begin
                        start_hdr = 1'b1;
                    end else if (tag == TAG_EOP) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (tag == TAG_SOP) begin
                        start_hdr = 1'b1;
                    end else if (!o_full) begin
                        // Stray word outside a packet; silent when full.
                        drop_d = 1'b1;
                    end
                end
            endcase

            // Header is always placed at the committed pointer, which is
            // also where any rollback in this cycle lands.
            if (start_hdr) begin
                if (cmt_full) begin
                    // No room for the header: quietly ignore the whole packet.
                    state_d = ST_SKIP;
                end else if (len_ok(hdr_len)) begin
                    we       = 1'b1;
                    waddr    = wr_cmt[AW-1:0];
                    wr_ptr_d = wr_cmt + PTR_ONE;
                    len_d    = hdr_len;
                    cnt_d    = 8'd1;
                    state_d  = ST_RECV;
                end else begin
                    drop_d  = 1'b1;
                    state_d = ST_SKIP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            o_drop     <= 1'b0;
            o_pkt_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            wr_ptr  <= wr_ptr_d;
            wr_cmt  <= wr_cmt_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            o_drop  <= drop_d;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pkt_inc) begin
                o_pkt_cnt <= o_pkt_cnt + 8'd1;
            end
            if (drop_d) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

    aes_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (i_data_in),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (o_data_out)
    );

endmodule

// File: tb/tb_aes_pkt_in_fifo.sv
// tb_aes_pkt_in_fifo: directed self-checking bench for aes_pkt_in_fifo.
// Inputs are driven on the falling edge, outputs checked on the falling edge.
module tb_aes_pkt_in_fifo;

    localparam int AW = 6;
    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_wr = 1'b0;
    logic [DW-1:0] i_data_in = '0;
    logic          o_full;
    logic          i_rd = 1'b0;
    logic [DW-1:0] o_data_out;
    logic          o_empty;
    logic          o_drop;
    logic [7:0]    o_pkt_cnt;
    logic [7:0]    o_drop_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    int            drop_seen = 0;
    logic [DW-1:0] exp_q[$];

    aes_pkt_in_fifo #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (i_wr),
        .i_data_in  (i_data_in),
        .o_full     (o_full),
        .i_rd       (i_rd),
        .o_data_out (o_data_out),
        .o_empty    (o_empty),
        .o_drop     (o_drop),
        .o_pkt_cnt  (o_pkt_cnt),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    // A registered pulse is seen exactly once at the following rising edge.
    always @(posedge clk) begin
        if (o_drop === 1'b1) drop_seen++;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sop_w(input logic [31:0] hdr);
        return {2'b01, hdr};
    endfunction

    function automatic logic [DW-1:0] body_w(input logic [31:0] hdr, input int idx);
        return {2'b00, hdr[15:0], 16'(idx)};
    endfunction

    function automatic logic [DW-1:0] eop_w();
        return {2'b10, 32'hffff0000};
    endfunction

    task automatic put(input logic [DW-1:0] w);
        i_wr      = 1'b1;
        i_data_in = w;
        @(negedge clk);
        i_wr      = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full packet of n words: header, n-2 body words, EOP.
    task automatic send_pkt(input logic [31:0] hdr, input int n, input bit commit);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            if (k == 0) w = sop_w(hdr);
            else if (k == n - 1) w = eop_w();
            else w = body_w(hdr, k);
            if (commit) exp_q.push_back(w);
            put(w);
        end
    endtask

    task automatic drain(input string tag, input int n);
        logic [DW-1:0] e;
        for (int k = 0; k < n; k++) begin
            i_rd = 1'b1;
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check(tag, o_data_out, e);
        end
        i_rd = 1'b0;
    endtask

    // Reader that only strobes when data is visible; bounded by a cycle budget.
    task automatic reader(input string tag, input int n);
        int  got = 0;
        int  budget = 400;
        bit  pend;
        logic [DW-1:0] e;
        while (got < n && budget > 0) begin
            pend = !o_empty;
            i_rd = pend;
            @(negedge clk);
            budget--;
            if (pend) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check(tag, o_data_out, e);
                got++;
            end
        end
        i_rd = 1'b0;
        if (got < n) check({tag, "_timeout"}, DW'(got), DW'(n));
    endtask

    initial begin
        int  d0;
        bit  saw_ready;

        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_empty", DW'(o_empty), DW'(1));
        check("rst_full", DW'(o_full), DW'(0));
        check("rst_drop", DW'(o_drop), DW'(0));
        check("rst_pkt_cnt", DW'(o_pkt_cnt), DW'(0));
        check("rst_drop_cnt", DW'(o_drop_cnt), DW'(0));
        check("rst_data", o_data_out, DW'(0));

        // Single 25-word packet: nothing readable before the EOP commit.
        saw_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            logic [DW-1:0] w;
            if (k == 0) w = sop_w(32'h00002a19);
            else if (k == 24) w = eop_w();
            else w = body_w(32'h00002a19, k);
            if (k < 24 && !o_empty) saw_ready = 1'b1;
            exp_q.push_back(w);
            put(w);
        end
        check("p25_early_ready", DW'(saw_ready), DW'(0));
        check("p25_ready_after_eop", DW'(o_empty), DW'(0));
        check("p25_pkt_cnt", DW'(o_pkt_cnt), DW'(1));
        drain("p25_data", 25);
        check("p25_empty_after", DW'(o_empty), DW'(1));

        // Read while empty is ignored and the output holds the last word.
        i_rd = 1'b1;
        tick(1);
        i_rd = 1'b0;
        check("rd_empty_hold", o_data_out, eop_w());

        // Back-to-back 27 and 29 word packets with a concurrent reader.
        d0 = drop_seen;
        fork
            begin
                send_pkt(32'h0000281b, 27, 1'b1);
                send_pkt(32'h0000271d, 29, 1'b1);
            end
            reader("b2b_data", 56);
        join
        tick(2);
        check("b2b_pkt_cnt", DW'(o_pkt_cnt), DW'(3));
        check("b2b_drop_cnt", DW'(o_drop_cnt), DW'(0));
        check("b2b_empty", DW'(o_empty), DW'(1));

        // Early EOP at word 20 of a 25-word packet.
        d0 = drop_seen;
        put(sop_w(32'h00002a19));
        for (int k = 1; k < 19; k++) put(body_w(32'h00002a19, k));
        put(eop_w());
        tick(2);
        check("early_eop_pulses", DW'(drop_seen - d0), DW'(1));
        check("early_eop_empty", DW'(o_empty), DW'(1));
        check("early_eop_drop_cnt", DW'(o_drop_cnt), DW'(1));

        // Header interrupted by a new header; only the second packet survives.
        d0 = drop_seen;
        put(sop_w(32'h00002a19));
        for (int k = 1; k < 10; k++) put(body_w(32'h00002a19, k));
        send_pkt(32'h0000281b, 27, 1'b1);
        tick(2);
        check("resync_pulses", DW'(drop_seen - d0), DW'(1));
        check("resync_drop_cnt", DW'(o_drop_cnt), DW'(2));
        check("resync_pkt_cnt", DW'(o_pkt_cnt), DW'(4));
        drain("resync_data", 27);
        check("resync_empty", DW'(o_empty), DW'(1));

        // Reader stalled: third 25-word packet overflows at word 15.
        send_pkt(32'h00002a19, 25, 1'b1);
        send_pkt(32'h00002a19, 25, 1'b1);
        d0 = drop_seen;
        put(sop_w(32'h00002a19));
        for (int k = 1; k < 14; k++) put(body_w(32'h00002a19, k));
        check("ovf_full", DW'(o_full), DW'(1));
        for (int k = 14; k < 24; k++) put(body_w(32'h00002a19, k));
        put(eop_w());
        tick(2);
        check("ovf_pulses", DW'(drop_seen - d0), DW'(1));
        check("ovf_drop_cnt", DW'(o_drop_cnt), DW'(3));
        check("ovf_pkt_cnt", DW'(o_pkt_cnt), DW'(6));
        check("ovf_not_full", DW'(o_full), DW'(0));
        drain("ovf_data", 50);
        check("ovf_empty", DW'(o_empty), DW'(1));

        // Stray body word in IDLE, then a bad-length header whose tail is skipped.
        d0 = drop_seen;
        put(body_w(32'h0, 7));
        put(sop_w(32'h0000001a));
        for (int k = 1; k < 25; k++) put(body_w(32'h1a, k));
        put(eop_w());
        tick(2);
        check("stray_badlen_pulses", DW'(drop_seen - d0), DW'(2));
        check("stray_badlen_drop_cnt", DW'(o_drop_cnt), DW'(5));
        check("stray_badlen_empty", DW'(o_empty), DW'(1));

        // Reset in the middle of a packet, then one clean packet.
        put(sop_w(32'h00002a19));
        for (int k = 1; k < 10; k++) put(body_w(32'h00002a19, k));
        #2 rst_n = 1'b0;
        tick(1);
        check("mid_rst_empty", DW'(o_empty), DW'(1));
        check("mid_rst_pkt_cnt", DW'(o_pkt_cnt), DW'(0));
        check("mid_rst_drop_cnt", DW'(o_drop_cnt), DW'(0));
        check("mid_rst_data", o_data_out, DW'(0));
        rst_n = 1'b1;
        tick(1);
        send_pkt(32'h00002a19, 25, 1'b1);
        check("post_rst_pkt_cnt", DW'(o_pkt_cnt), DW'(1));
        check("post_rst_drop_cnt", DW'(o_drop_cnt), DW'(0));
        drain("post_rst_data", 25);
        check("post_rst_empty", DW'(o_empty), DW'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
